// File: rtl/multiply_control_if.sv
// Switch/button inputs, external adder hookup and display outputs of the
// add/shift multiplier sequencer, grouped for a single port.
interface multiply_control_if #(
   parameter int WIDTH = 8
);
   logic             Run;
   logic             ClearA_LoadB;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] adder_a;
   logic [WIDTH-1:0] adder_b;
   logic             adder_cin;
   logic [WIDTH-1:0] adder_sum;
   logic             adder_x;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             Xval;
   logic             Done;

   modport master (
      output Run, ClearA_LoadB, S, adder_sum, adder_x,
      input  adder_a, adder_b, adder_cin, Aval, Bval, Xval, Done
   );

   modport slave (
      input  Run, ClearA_LoadB, S, adder_sum, adder_x,
      output adder_a, adder_b, adder_cin, Aval, Bval, Xval, Done
   );
endinterface

// File: rtl/multiply_control.sv
// Sequencer for the signed add/shift multiplier; product lands in {A,B}, sign in X.
// Latency: Run sampled in IDLE, 2*WIDTH ADD/SHIFT cycles, then HOLD with Done=1.
// No backpressure: Run is a level; HOLD waits for Run to drop before re-arming.
module multiply_control #(
   parameter int WIDTH = 8
) (
   input  logic              Clk,
   input  logic              Reset_n,
   multiply_control_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;

   state_t           state, state_n;
   logic             x, x_n;
   logic [WIDTH-1:0] a, a_n;
   logic [WIDTH-1:0] b, b_n;
   logic [WIDTH-1:0] m, m_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             last;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         x     <= 1'b0;
         a     <= '0;
         b     <= '0;
         m     <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         x     <= x_n;
         a     <= a_n;
         b     <= b_n;
         m     <= m_n;
         cnt   <= cnt_n;
      end
   end

   assign last = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_n = state;
      x_n     = x;
      a_n     = a;
      b_n     = b;
      m_n     = m;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            // Run wins over ClearA_LoadB; B is kept so products can be chained.
            if (bus.Run) begin
               a_n     = '0;
               x_n     = 1'b0;
               m_n     = bus.S;
               cnt_n   = '0;
               state_n = ADD;
            end else if (bus.ClearA_LoadB) begin
               a_n = '0;
               x_n = 1'b0;
               b_n = bus.S;
            end
         end
         ADD: begin
            if (b[0]) begin
               a_n = bus.adder_sum;
               x_n = bus.adder_x;
            end
            state_n = SHIFT;
         end
         SHIFT: begin
            a_n = {x, a[WIDTH-1:1]};
            b_n = {a[0], b[WIDTH-1:1]};
            if (last) begin
               state_n = HOLD;
            end else begin
               cnt_n   = cnt + CW'(1);
               state_n = ADD;
            end
         end
         HOLD: begin
            if (!bus.Run) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // The multiplier's sign bit carries negative weight, so the last step subtracts M.
   assign bus.adder_a   = a;
   assign bus.adder_b   = last ? ~m : m;
   assign bus.adder_cin = last;
   assign bus.Aval      = a;
   assign bus.Bval      = b;
   assign bus.Xval      = x;
   assign bus.Done      = (state == HOLD);
endmodule

// File: tb/tb_multiply_control.sv
// Directed and randomized checks of multiply_control against a signed-product model,
// with the sign-extending adder modelled beside the DUT.
module tb_multiply_control;
   localparam int WIDTH = 8;

   logic Clk;
   logic Reset_n;
   int   vectors     = 0;
   int   miscompares = 0;

   multiply_control_if #(.WIDTH(WIDTH)) bus ();

   multiply_control #(.WIDTH(WIDTH)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   // External 8-bit adder with 9th sign-extension bit.
   logic [8:0] sum9;
   assign sum9 = {bus.adder_a[7], bus.adder_a} + {bus.adder_b[7], bus.adder_b}
                 + {8'd0, bus.adder_cin};
   assign bus.adder_sum = sum9[7:0];
   assign bus.adder_x   = sum9[8];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clb(input logic [7:0] v);
      bus.S            = v;
      bus.ClearA_LoadB = 1'b1;
      tick();
      bus.ClearA_LoadB = 1'b0;
      chk("clb_A", {24'd0, bus.Aval}, 32'd0);
      chk("clb_B", {24'd0, bus.Bval}, {24'd0, v});
      chk("clb_X", {31'd0, bus.Xval}, 32'd0);
   endtask

   // Starts a multiply of m by current B; leaves Run high in HOLD.
   task automatic run_mult(input logic [7:0] m, input logic [7:0] bstart,
                           input bit clb_pulse, input string tag);
      logic signed [15:0] p;
      int k;
      int done_k;
      p = $signed({{8{m[7]}}, m}) * $signed({{8{bstart[7]}}, bstart});
      bus.S   = m;
      bus.Run = 1'b1;
      tick();                    // edge that samples Run
      bus.S  = 8'($urandom);     // switches may move during the run
      k      = 0;
      done_k = -1;
      while (k < 40 && done_k < 0) begin
         if (clb_pulse && k == 5) bus.ClearA_LoadB = 1'b1;
         if (k == 6) bus.ClearA_LoadB = 1'b0;
         if (k == 13) begin
            chk({tag, "_cin_early"}, {31'd0, bus.adder_cin}, 32'd0);
            chk({tag, "_b_early"}, {24'd0, bus.adder_b}, {24'd0, m});
         end
         if (k == 14) begin
            chk({tag, "_cin_last"}, {31'd0, bus.adder_cin}, 32'd1);
            chk({tag, "_b_last"}, {24'd0, bus.adder_b}, {24'd0, ~m});
         end
         if (bus.Done) done_k = k;
         else begin
            tick();
            k++;
         end
      end
      // Done appears 2*WIDTH edges after the sampling edge (edge 17 counting it).
      chk({tag, "_latency"}, done_k, 2 * WIDTH);
      chk({tag, "_prod"}, {16'd0, bus.Aval, bus.Bval}, {16'd0, p});
      chk({tag, "_x"}, {31'd0, bus.Xval}, {31'd0, p[15]});
   endtask

   task automatic release_run();
      bus.Run = 1'b0;
      tick();
      chk("release_done", {31'd0, bus.Done}, 32'd0);
   endtask

   initial begin
      logic [7:0]  m;
      logic [7:0]  b;
      logic [15:0] held;
      int          stuck;

      bus.Run          = 1'b0;
      bus.ClearA_LoadB = 1'b0;
      bus.S            = 8'h00;
      Reset_n          = 1'b0;
      #12;
      chk("rst_A", {24'd0, bus.Aval}, 32'd0);
      chk("rst_B", {24'd0, bus.Bval}, 32'd0);
      chk("rst_X", {31'd0, bus.Xval}, 32'd0);
      chk("rst_done", {31'd0, bus.Done}, 32'd0);
      chk("rst_cin", {31'd0, bus.adder_cin}, 32'd0);
      Reset_n = 1'b1;
      tick();

      // pos * pos: 7 * 59 = 413
      clb(8'h07);
      run_mult(8'h3B, 8'h07, 1'b0, "pos_pos");
      chk("pos_pos_const", {16'd0, bus.Aval, bus.Bval}, 32'h019D);
      release_run();

      // neg * pos: -7 * 59 = -413
      clb(8'hF9);
      run_mult(8'h3B, 8'hF9, 1'b0, "neg_pos");
      chk("neg_pos_const", {16'd0, bus.Aval, bus.Bval}, 32'hFE63);
      release_run();

      // -128 * -128 and 0 * -1
      clb(8'h80);
      run_mult(8'h80, 8'h80, 1'b0, "min_min");
      chk("min_min_const", {16'd0, bus.Aval, bus.Bval}, 32'h4000);
      release_run();
      clb(8'hFF);
      run_mult(8'h00, 8'hFF, 1'b0, "zero");
      release_run();

      // Run held long with a ClearA_LoadB pulse mid-run: single multiply, stays in HOLD.
      clb(8'hD3);
      run_mult(8'h65, 8'hD3, 1'b1, "hold");
      held  = {bus.Aval, bus.Bval};
      stuck = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!bus.Done || {bus.Aval, bus.Bval} != held) stuck++;
      end
      chk("hold_stable", stuck, 0);
      release_run();

      // Asynchronous abort partway through, then a clean rerun.
      clb(8'h07);
      bus.S   = 8'h3B;
      bus.Run = 1'b1;
      for (int i = 0; i < 9; i++) @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("abort_A", {24'd0, bus.Aval}, 32'd0);
      chk("abort_B", {24'd0, bus.Bval}, 32'd0);
      chk("abort_X", {31'd0, bus.Xval}, 32'd0);
      chk("abort_done", {31'd0, bus.Done}, 32'd0);
      chk("abort_cin", {31'd0, bus.adder_cin}, 32'd0);
      chk("abort_addb", {24'd0, bus.adder_b}, 32'd0);
      bus.Run = 1'b0;
      #3;
      Reset_n = 1'b1;
      tick();
      clb(8'h07);
      run_mult(8'h3B, 8'h07, 1'b0, "rerun");
      chk("rerun_const", {16'd0, bus.Aval, bus.Bval}, 32'h019D);
      release_run();

      // Random operands; every third multiply chains on the previous low byte.
      for (int i = 0; i < 24; i++) begin
         if (i % 3 == 2) begin
            b = bus.Bval;
         end else begin
            b = 8'($urandom);
            clb(b);
         end
         m = 8'($urandom);
         run_mult(m, b, 1'b0, "rand");
         release_run();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
